psmac_seq_acc: RTL and testbench

//  Digit-serial sequencer and accumulator wrapped around one external 2x2-bit mfu.

---
 rtl/psmac_seq_acc.sv | 195 +++++++++++++++++++
 tb/tb_psmac_seq_acc.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psmac_seq_acc.sv
// Digit-serial multiply-accumulate sequencer around an external 2x2-bit multiplier.
// Operands of 2/4/8 bits are split into 2-bit digits and products are shift-added into a wrapping accumulator.
module psmac_seq_acc #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [1:0]       in_prec,
    input  logic             in_a_signed,
    input  logic             in_b_signed,
    input  logic             in_clr,
    input  logic             in_last,
    output logic [1:0]       mfu_a,
    output logic [1:0]       mfu_b,
    output logic [1:0]       mfu_sel,
    input  logic [3:0]       mfu_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic [1:0]       dl_q;
    logic             a_s_q;
    logic             b_s_q;
    logic             last_q;
    logic [1:0]       i_q;
    logic [1:0]       j_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] out_acc_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [1:0]       mfu_a_q;
    logic [1:0]       mfu_b_q;
    logic [1:0]       mfu_sel_q;

    logic [ACC_W-1:0] prod_ext_s;
    logic [3:0]       shift_s;
    logic [1:0]       i_d;
    logic [1:0]       j_d;
    logic             final_s;
    logic [1:0]       dl_in_s;

    function automatic logic [1:0] digit(input logic [7:0] x, input logic [1:0] idx);
        logic [1:0] r;
        case (idx)
            2'd0:    r = x[1:0];
            2'd1:    r = x[3:2];
            2'd2:    r = x[5:4];
            default: r = x[7:6];
        endcase
        return r;
    endfunction

    // Index of the most significant digit for a precision code; 11 behaves as 10.
    function automatic logic [1:0] last_idx(input logic [1:0] prec);
        logic [1:0] r;
        case (prec)
            2'd0:    r = 2'd0;
            2'd1:    r = 2'd1;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    // Product extension, digit-pair weighting and next (i,j) pair for the RUN step.
    always_comb begin
        dl_in_s = last_idx(in_prec);
        if (mfu_sel_q == 2'b00) begin
            prod_ext_s = {{(ACC_W-4){1'b0}}, mfu_p};
        end else begin
            prod_ext_s = {{(ACC_W-4){mfu_p[3]}}, mfu_p};
        end
        shift_s = {1'b0, i_q, 1'b0} + {1'b0, j_q, 1'b0};
        acc_d   = acc_q + (prod_ext_s << shift_s);
        final_s = (i_q == dl_q) && (j_q == dl_q);
        if (j_q == dl_q) begin
            i_d = i_q + 2'd1;
            j_d = 2'd0;
        end else begin
            i_d = i_q;
            j_d = j_q + 2'd1;
        end
    end

    // Sequencer FSM; the multiplier drive and handshake outputs are all registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            dl_q        <= 2'd0;
            a_s_q       <= 1'b0;
            b_s_q       <= 1'b0;
            last_q      <= 1'b0;
            i_q         <= 2'd0;
            j_q         <= 2'd0;
            acc_q       <= {ACC_W{1'b0}};
            out_acc_q   <= {ACC_W{1'b0}};
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            mfu_a_q     <= 2'd0;
            mfu_b_q     <= 2'd0;
            mfu_sel_q   <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= in_a;
                        b_q        <= in_b;
                        dl_q       <= dl_in_s;
                        a_s_q      <= in_a_signed;
                        b_s_q      <= in_b_signed;
                        last_q     <= in_last;
                        i_q        <= 2'd0;
                        j_q        <= 2'd0;
                        mfu_a_q    <= in_a[1:0];
                        mfu_b_q    <= in_b[1:0];
                        mfu_sel_q  <= {in_a_signed & (dl_in_s == 2'd0),
                                       in_b_signed & (dl_in_s == 2'd0)};
                        if (in_clr) begin
                            acc_q <= {ACC_W{1'b0}};
                        end else begin
                            acc_q <= acc_q;
                        end
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (final_s) begin
                        mfu_a_q   <= 2'd0;
                        mfu_b_q   <= 2'd0;
                        mfu_sel_q <= 2'd0;
                        if (last_q) begin
                            out_valid_q <= 1'b1;
                            out_acc_q   <= acc_d;
                            state_q     <= DONE;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= IDLE;
                        end
                    end else begin
                        i_q       <= i_d;
                        j_q       <= j_d;
                        mfu_a_q   <= digit(a_q, i_d);
                        mfu_b_q   <= digit(b_q, j_d);
                        mfu_sel_q <= {a_s_q & (i_d == dl_q), b_s_q & (j_d == dl_q)};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                    mfu_a_q     <= 2'd0;
                    mfu_b_q     <= 2'd0;
                    mfu_sel_q   <= 2'd0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign mfu_a     = mfu_a_q;
    assign mfu_b     = mfu_b_q;
    assign mfu_sel   = mfu_sel_q;

endmodule

// File: tb/tb_psmac_seq_acc.sv
// Bench for psmac_seq_acc: directed scenarios plus random ops, scored against a whole-operand multiply-accumulate model.
module tb_psmac_seq_acc;

    localparam int ACC_W = 24;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_a = 8'd0;
    logic [7:0]       in_b = 8'd0;
    logic [1:0]       in_prec = 2'd0;
    logic             in_a_signed = 1'b0;
    logic             in_b_signed = 1'b0;
    logic             in_clr = 1'b0;
    logic             in_last = 1'b0;
    logic [1:0]       mfu_a;
    logic [1:0]       mfu_b;
    logic [1:0]       mfu_sel;
    logic [3:0]       mfu_p;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;

    int checks = 0;
    int errors = 0;
    logic [ACC_W-1:0] exp_q[$];
    logic [ACC_W-1:0] m_acc = '0;
    logic rand_en = 1'b0;
    logic forced_ready = 1'b1;

    psmac_seq_acc #(.ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_prec(in_prec),
        .in_a_signed(in_a_signed), .in_b_signed(in_b_signed),
        .in_clr(in_clr), .in_last(in_last),
        .mfu_a(mfu_a), .mfu_b(mfu_b), .mfu_sel(mfu_sel), .mfu_p(mfu_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc)
    );

    always #5 clk = ~clk;

    // External 2x2 multiplier: each digit is signed when its select bit is set.
    int mav, mbv, mpv;
    always_comb begin
        mav = (mfu_sel[1] && mfu_a[1]) ? int'(mfu_a) - 4 : int'(mfu_a);
        mbv = (mfu_sel[0] && mfu_b[1]) ? int'(mfu_b) - 4 : int'(mfu_b);
        mpv = mav * mbv;
        mfu_p = mpv[3:0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int opval(input logic [7:0] x, input logic [1:0] prec, input logic s);
        int w;
        int v;
        w = (prec == 2'd0) ? 2 : (prec == 2'd1) ? 4 : 8;
        v = int'(x) & ((1 << w) - 1);
        if (s && v >= (1 << (w - 1))) v -= (1 << w);
        return v;
    endfunction

    // Downstream ready: random in the random phase, otherwise the directed level.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_en ? ($urandom_range(0, 3) != 0) : forced_ready;
        end
    end

    // Output monitor: every accepted result is popped from the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%0h expected=none", out_acc);
            end else begin
                chk("out_acc", 32'(out_acc), 32'(exp_q.pop_front()));
            end
        end
    end

    // Called at posedge+1; returns at accepting edge+1.
    task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] prec,
                           input logic sa, input logic sb, input logic clr, input logic last);
        int cnt;
        cnt = 0;
        in_a = a; in_b = b; in_prec = prec;
        in_a_signed = sa; in_b_signed = sb; in_clr = clr; in_last = last;
        in_valid = 1'b1;
        while (!in_ready && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (cnt >= 200) chk("accept_timeout", 32'(cnt), 32'd0);
        if (clr) m_acc = '0;
        m_acc = m_acc + ACC_W'(opval(a, prec, sa) * opval(b, prec, sb));
        if (last) exp_q.push_back(m_acc);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 8'($urandom); in_b = 8'($urandom);
    endtask

    // Waits for out_valid, checking the multiplier drive of every digit pair on the way.
    task automatic run_watch(input int nexp, input logic [7:0] a, input logic [7:0] b,
                             input int d, input logic sa, input logic sb);
        int k;
        int i;
        int j;
        k = 0;
        while (!out_valid && k < 64) begin
            if (k < d * d) begin
                i = k / d;
                j = k % d;
                chk("mfu_a", 32'(mfu_a), 32'(a[2*i +: 2]));
                chk("mfu_b", 32'(mfu_b), 32'(b[2*j +: 2]));
                chk("mfu_sel", 32'(mfu_sel), 32'({sa && (i == d - 1), sb && (j == d - 1)}));
            end
            @(posedge clk); #1;
            k++;
        end
        chk("latency", 32'(k), 32'(nexp));
        chk("mfu_idle", 32'({mfu_a, mfu_b, mfu_sel}), 32'd0);
    endtask

    initial begin
        int cnt;
        logic [1:0] p;
        logic [7:0] ra;
        logic [7:0] rb;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_acc", 32'(out_acc), 32'd0);
        chk("rst_mfu", 32'({mfu_a, mfu_b, mfu_sel}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // 2-bit unsigned: 3*3
        send_op(8'd3, 8'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        run_watch(1, 8'd3, 8'd3, 1, 1'b0, 1'b0);
        chk("t1_acc", 32'(out_acc), 32'd9);
        @(posedge clk); #1;

        // 8-bit signed: -128*-128
        send_op(8'h80, 8'h80, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
        run_watch(16, 8'h80, 8'h80, 4, 1'b1, 1'b1);
        chk("t2_acc", 32'(out_acc), 32'h004000);
        @(posedge clk); #1;

        // 4-bit signed x unsigned: -8*15
        send_op(8'h08, 8'h0F, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1);
        run_watch(4, 8'h08, 8'h0F, 2, 1'b1, 1'b0);
        chk("t3_acc", 32'(out_acc), 32'hFFFF88);
        @(posedge clk); #1;

        // Three accumulated 8-bit signed ops, one result
        send_op(8'd100, 8'd100, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (16) @(posedge clk);
        #1;
        chk("t4_ready1", 32'({in_ready, out_valid}), 32'b10);
        send_op(8'hCE, 8'd3, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (16) @(posedge clk);
        #1;
        chk("t4_ready2", 32'({in_ready, out_valid}), 32'b10);
        send_op(8'd127, 8'h80, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
        run_watch(16, 8'd127, 8'h80, 4, 1'b1, 1'b1);
        chk("t4_acc", 32'(out_acc), 32'hFFE6FA);
        @(posedge clk); #1;

        // Output stall with ignored input pulses
        forced_ready = 1'b0;
        send_op(8'd3, 8'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        run_watch(1, 8'd3, 8'd3, 1, 1'b0, 1'b0);
        for (int s = 0; s < 5; s++) begin
            in_valid = s[0];
            in_clr = 1'b1; in_last = 1'b1;
            @(posedge clk); #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_acc", 32'(out_acc), 32'd9);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        forced_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("release_state", 32'({out_valid, in_ready}), 32'b01);
        chk("release_acc_hold", 32'(out_acc), 32'd9);

        // Reset in the middle of an 8-bit op
        send_op(8'h55, 8'h33, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        m_acc = '0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_mfu", 32'({mfu_a, mfu_b, mfu_sel}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_idle", 32'(in_ready), 32'd1);
        send_op(8'h05, 8'h09, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1);
        run_watch(4, 8'h05, 8'h09, 2, 1'b1, 1'b1);
        chk("t6_acc", 32'(out_acc), 32'hFFFFDD);
        @(posedge clk); #1;

        // Random ops with random downstream back-pressure
        rand_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            p = 2'($urandom);
            ra = 8'($urandom);
            rb = 8'($urandom);
            send_op(ra, rb, p, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                    (n == 59) || ($urandom_range(0, 2) == 0));
        end
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 1000) begin
            @(posedge clk); #1;
            cnt++;
        end
        rand_en = 1'b0;
        forced_ready = 1'b1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("final_idle", 32'({in_ready, out_valid}), 32'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
